sleep_wake_sequencer: RTL

Power-state controller for the stereo processing datapath. It consumes the zero detector's sleep indication and drains the datapath before gating it off. While asleep it watches the incoming L/R frames. On any nonzero sample or an external force_wake it re-enables the core and holds the output muted until the datapath delivers a valid frame.

---
 rtl/sws_pkg.sv | 15 +
 rtl/sleep_wake_sequencer_if.sv | 28 ++
 rtl/sws_timer.sv | 32 +++
 rtl/sleep_wake_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/sws_pkg.sv
// Shared constants for the sleep/wake power sequencer: state encodings and default timings.
package sws_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_ACTIVE = 2'd0;
  localparam logic [ST_W-1:0] ST_DRAIN  = 2'd1;
  localparam logic [ST_W-1:0] ST_SLEEP  = 2'd2;
  localparam logic [ST_W-1:0] ST_WAKE   = 2'd3;

  localparam int SWS_DRAIN_CYCLES_DEF = 16;
  localparam int SWS_WAKE_CYCLES_DEF  = 64;
  localparam int SWS_CNT_W_DEF        = 8;

endpackage

// File: rtl/sleep_wake_sequencer_if.sv
// Frame/status bundle between the stereo datapath and the sleep/wake sequencer.
interface sleep_wake_sequencer_if;
  import sws_pkg::*;

  logic            sample_strobe;
  logic [15:0]     InputL;
  logic [15:0]     InputR;
  logic            zero_detect;
  logic            pipe_busy;
  logic            OutReady;
  logic            force_wake;
  logic            core_en;
  logic            sleep_status;
  logic            mute;
  logic            wake_pulse;
  logic [ST_W-1:0] state;

  modport master (
    output sample_strobe, InputL, InputR, zero_detect, pipe_busy, OutReady, force_wake,
    input  core_en, sleep_status, mute, wake_pulse, state
  );

  modport slave (
    input  sample_strobe, InputL, InputR, zero_detect, pipe_busy, OutReady, force_wake,
    output core_en, sleep_status, mute, wake_pulse, state
  );

endinterface

// File: rtl/sws_timer.sv
// Saturating up-counter with synchronous clear and terminal-count compare.
module sws_timer #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/sleep_wake_sequencer.sv
// Drains the stereo datapath before gating it off, and wakes it on any nonzero frame or force_wake.
module sleep_wake_sequencer
  import sws_pkg::*;
#(
  parameter int DRAIN_CYCLES = SWS_DRAIN_CYCLES_DEF,
  parameter int WAKE_CYCLES  = SWS_WAKE_CYCLES_DEF,
  parameter int CNT_W        = SWS_CNT_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  sleep_wake_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LIM  = CNT_W'(WAKE_CYCLES - 1);

  logic [ST_W-1:0] state_q, state_d;
  logic            armed_q, armed_d;
  logic            mute_hold_q, mute_hold_d;
  logic            core_en_q, sleep_status_q, mute_q, wake_pulse_q;
  logic            core_en_d, sleep_status_d, mute_d, wake_pulse_d;
  logic            nz, t_clr, t_en, t_tc;
  logic [CNT_W-1:0] t_limit;

  assign nz      = bus.sample_strobe & ((bus.InputL != '0) | (bus.InputR != '0));
  assign t_limit = (state_q == ST_WAKE) ? WAKE_LIM : DRAIN_LIM;

  sws_timer #(.CNT_W(CNT_W)) u_timer (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr_i   (t_clr),
    .en_i    (t_en),
    .limit_i (t_limit),
    .tc_o    (t_tc)
  );

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    mute_hold_d = mute_hold_q;
    t_clr       = 1'b0;
    t_en        = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (bus.OutReady)     mute_hold_d = 1'b0;
        if (!bus.zero_detect) armed_d     = 1'b1;
        if (armed_q && bus.zero_detect && !bus.force_wake) begin
          state_d = ST_DRAIN;
          t_clr   = 1'b1;
        end
      end
      // Abort conditions outrank the drain timer
      ST_DRAIN: begin
        if (bus.force_wake || nz || !bus.zero_detect)
          state_d = ST_ACTIVE;
        else if (bus.pipe_busy)
          t_clr = 1'b1;
        else if (t_tc)
          state_d = ST_SLEEP;
        else
          t_en = 1'b1;
      end
      ST_SLEEP: begin
        if (nz || bus.force_wake) begin
          state_d     = ST_WAKE;
          t_clr       = 1'b1;
          armed_d     = 1'b0;
          mute_hold_d = 1'b1;
        end
      end
      default: begin
        if (t_tc) state_d = ST_ACTIVE;
        else      t_en    = 1'b1;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state
  always_comb begin
    core_en_d      = (state_d != ST_SLEEP);
    sleep_status_d = (state_d == ST_SLEEP);
    mute_d         = (state_d == ST_SLEEP || state_d == ST_WAKE) ? 1'b1 : mute_hold_d;
    wake_pulse_d   = (state_q == ST_SLEEP) && (state_d == ST_WAKE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= ST_ACTIVE;
      armed_q        <= 1'b1;
      mute_hold_q    <= 1'b1;
      core_en_q      <= 1'b1;
      sleep_status_q <= 1'b0;
      mute_q         <= 1'b1;
      wake_pulse_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      mute_hold_q    <= mute_hold_d;
      core_en_q      <= core_en_d;
      sleep_status_q <= sleep_status_d;
      mute_q         <= mute_d;
      wake_pulse_q   <= wake_pulse_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.core_en      = core_en_q;
  assign bus.sleep_status = sleep_status_q;
  assign bus.mute         = mute_q;
  assign bus.wake_pulse   = wake_pulse_q;

endmodule
